// File: rtl/control_unit_if.sv
// control_unit_if: handshake / status bundle between control_unit and data_path.
//   master : control_unit side (drives enables, busy, done, iter_cnt)
//   slave  : data_path / environment side (drives start, output8)
//   Signals: start, output8[WIDTH], Enable3, Enable7, Enable9, Enable10,
//            busy, done, iter_cnt[CNT_W]; with CONTROL_UNIT_ABORT_EN also
//            abort (to controller) and aborted (from controller).
interface control_unit_if #(
  parameter int WIDTH = 32,
  parameter int ITER  = 8
);
  localparam int CNT_W = $clog2(ITER + 1);

  logic             start;
  logic [WIDTH-1:0] output8;
  logic             Enable3;
  logic             Enable7;
  logic             Enable9;
  logic             Enable10;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_cnt;
`ifdef CONTROL_UNIT_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (input start, output8, abort,
                  output Enable3, Enable7, Enable9, Enable10, busy, done, iter_cnt, aborted);
  modport slave  (output start, output8, abort,
                  input Enable3, Enable7, Enable9, Enable10, busy, done, iter_cnt, aborted);
`else
  modport master (input start, output8,
                  output Enable3, Enable7, Enable9, Enable10, busy, done, iter_cnt);
  modport slave  (output start, output8,
                  input Enable3, Enable7, Enable9, Enable10, busy, done, iter_cnt);
`endif
endinterface

// File: rtl/control_unit.sv
// control_unit: ASM controller sequencing data_path enables.
//   IDLE -> LOAD (Enable3/7) -> COMPUTE (Enable9, up to ITER cycles, exits
//   early when output8==0) -> WRITE (Enable10) -> DONE (done pulse) -> IDLE.
// Ports: clk, rst_n (async, active low), bus (control_unit_if.master).
// Params: WIDTH (output8 width), ITER (max COMPUTE cycles, 1..65535);
//   must match the parameters of the connected interface.
// Option: CONTROL_UNIT_ABORT_EN adds bus.abort (jump to DONE from
//   LOAD/COMPUTE/WRITE) and the sticky bus.aborted flag.
module control_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 8
) (
  input logic            clk,
  input logic            rst_n,
  control_unit_if.master bus
);
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;

  typedef struct packed {
    logic e3, e7, e9, e10, busy, done;
  } outs_t;

  // Outputs are registered from the state being entered, so each one is
  // high exactly for the cycles spent in its state.
  function automatic outs_t dec(state_t s);
    outs_t o;
    o = '0;
    case (s)
      LOAD:    begin o.e3 = 1'b1; o.e7 = 1'b1; o.busy = 1'b1; end
      COMPUTE: begin o.e9 = 1'b1; o.busy = 1'b1; end
      WRITE:   begin o.e10 = 1'b1; o.busy = 1'b1; end
      DONE:    o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t           state;
  outs_t            o;
  logic [CNT_W-1:0] cnt;
  logic             abort_i;
  logic             last;

`ifdef CONTROL_UNIT_ABORT_EN
  assign abort_i = bus.abort;
`else
  assign abort_i = 1'b0;
`endif

  assign last = ((cnt + 1'b1) == ITER_C) || (bus.output8 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
            o     <= dec(LOAD);
            cnt   <= '0;
          end else begin
            state <= IDLE;
            o     <= dec(IDLE);
          end
        end
        LOAD: begin
          state <= abort_i ? DONE : COMPUTE;
          o     <= dec(abort_i ? DONE : COMPUTE);
        end
        COMPUTE: begin
          // counter advances on the exit edge too, so iter_cnt equals the
          // number of COMPUTE cycles actually spent
          cnt <= cnt + 1'b1;
          if (abort_i) begin
            state <= DONE;
            o     <= dec(DONE);
          end else if (last) begin
            state <= WRITE;
            o     <= dec(WRITE);
          end else begin
            state <= COMPUTE;
            o     <= dec(COMPUTE);
          end
        end
        WRITE: begin
          state <= DONE;
          o     <= dec(DONE);
        end
        DONE: begin
          state <= IDLE;
          o     <= dec(IDLE);
        end
        default: begin
          state <= IDLE;
          o     <= dec(IDLE);
        end
      endcase
    end
  end

`ifdef CONTROL_UNIT_ABORT_EN
  logic aborted_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      aborted_q <= 1'b0;
    else if (state == IDLE && bus.start)
      aborted_q <= 1'b0;
    else if (abort_i && (state == LOAD || state == COMPUTE || state == WRITE))
      aborted_q <= 1'b1;
  end
  assign bus.aborted = aborted_q;
`endif

  assign bus.Enable3  = o.e3;
  assign bus.Enable7  = o.e7;
  assign bus.Enable9  = o.e9;
  assign bus.Enable10 = o.e10;
  assign bus.busy     = o.busy;
  assign bus.done     = o.done;
  assign bus.iter_cnt = cnt;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: ITER=8 instance checked through a scoreboard
// (expected run profile pushed at stimulus time, popped at each done pulse),
// plus an ITER=1 instance checked directly.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_if #(.WIDTH(32), .ITER(8)) i8 ();
  control_unit_if #(.WIDTH(32), .ITER(1)) i1 ();

  control_unit #(.WIDTH(32), .ITER(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  control_unit #(.WIDTH(32), .ITER(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  typedef struct {
    int e3, e9, e10, iter, len, gap, ab;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(int e9, int e10, int iter, int len, int gap, int ab);
    exp_t e;
    e.e3 = 1; e.e9 = e9; e.e10 = e10; e.iter = iter; e.len = len; e.gap = gap; e.ab = ab;
    return e;
  endfunction

  // ---------------- monitor / scoreboard for ITER=8 ----------------
  int  m_e3, m_e9, m_e10, m_len, m_gap, m_idle;
  bit  m_in;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_in = 1'b0; m_idle = 0;
    end else begin
      chk("busy_eq", int'(i8.busy), int'(i8.Enable3 | i8.Enable9 | i8.Enable10));
      chk("e7_eq_e3", int'(i8.Enable7), int'(i8.Enable3));
      if (i8.Enable3 && !m_in) begin
        m_in = 1'b1; m_gap = m_idle;
        m_e3 = 0; m_e9 = 0; m_e10 = 0; m_len = 0;
      end
      if (m_in) begin
        m_len++;
        m_e3  += int'(i8.Enable3);
        m_e9  += int'(i8.Enable9);
        m_e10 += int'(i8.Enable10);
      end
      if (i8.done) begin
        if (sbq.size() == 0) chk("sb_unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_e3", m_e3, e.e3);
          chk("sb_e9", m_e9, e.e9);
          chk("sb_e10", m_e10, e.e10);
          chk("sb_iter", int'(i8.iter_cnt), e.iter);
          chk("sb_len", m_len, e.len);
          if (e.gap >= 0) chk("sb_gap", m_gap, e.gap);
`ifdef CONTROL_UNIT_ABORT_EN
          chk("sb_aborted", int'(i8.aborted), e.ab);
`endif
        end
        m_in = 1'b0; m_idle = 0;
      end else if (!m_in) m_idle++;
    end
  end

  // One start pulse on the ITER=8 instance; output8 forced to 0 during
  // COMPUTE cycle zero_at, abort raised during COMPUTE cycle abort_at.
  task automatic pulse_run(input int zero_at, input int abort_at);
    i8.start = 1'b1;
    @(posedge clk); #1 i8.start = 1'b0;
    chk("lat_e3", int'(i8.Enable3), 1);
    chk("lat_e9_low", int'(i8.Enable9), 0);
    @(posedge clk); #1;
    chk("lat_e9", int'(i8.Enable9), 1);
    for (int i = 1; i <= 20 && i8.Enable9; i++) begin
      if (i == zero_at) i8.output8 = 32'h0;
`ifdef CONTROL_UNIT_ABORT_EN
      if (i == abort_at) i8.abort = 1'b1;
`endif
      @(posedge clk); #1;
      i8.output8 = 32'hA5;
`ifdef CONTROL_UNIT_ABORT_EN
      i8.abort = 1'b0;
`endif
    end
    for (int t = 0; t < 20 && !i8.done; t++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", int'(i8.done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    i8.start = 1'b0; i8.output8 = 32'hA5;
    i1.start = 1'b0; i1.output8 = 32'hA5;
`ifdef CONTROL_UNIT_ABORT_EN
    i8.abort = 1'b0; i1.abort = 1'b0;
`endif
    #12;
    chk("rst_busy", int'(i8.busy), 0);
    chk("rst_done", int'(i8.done), 0);
    chk("rst_e3", int'(i8.Enable3), 0);
    chk("rst_iter", int'(i8.iter_cnt), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // full run, no early exit
    sbq.push_back(mk(8, 1, 8, 11, -1, 0));
    pulse_run(0, 0);
    chk("hold_iter_idle", int'(i8.iter_cnt), 8);
    repeat (3) @(posedge clk); #1;
    chk("hold_iter_idle2", int'(i8.iter_cnt), 8);

    // early exit on the 3rd COMPUTE edge
    sbq.push_back(mk(3, 1, 3, 6, -1, 0));
    pulse_run(3, 0);
    chk("early_iter_idle", int'(i8.iter_cnt), 3);

    // reset mid-COMPUTE at iter 3
    i8.start = 1'b1;
    @(posedge clk); #1 i8.start = 1'b0;
    for (int t = 0; t < 20 && i8.iter_cnt != 3; t++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_precond", int'(i8.iter_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_e9", int'(i8.Enable9), 0);
    chk("rst_mid_busy", int'(i8.busy), 0);
    chk("rst_mid_done", int'(i8.done), 0);
    chk("rst_mid_iter", int'(i8.iter_cnt), 0);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_idle_busy", int'(i8.busy), 0);
    chk("post_rst_idle_e3", int'(i8.Enable3), 0);

    // start held 30 cycles -> three back-to-back runs, one idle cycle apart
    sbq.push_back(mk(8, 1, 8, 11, -1, 0));
    sbq.push_back(mk(8, 1, 8, 11, 1, 0));
    sbq.push_back(mk(8, 1, 8, 11, 1, 0));
    i8.start = 1'b1;
    repeat (30) @(posedge clk);
    #1 i8.start = 1'b0;
    repeat (15) @(posedge clk); #1;
    chk("sb_drained_held", sbq.size(), 0);

    // ITER=1: exactly one COMPUTE cycle whatever output8 is
    for (int k = 0; k < 2; k++) begin
      int n9, nd;
      n9 = 0; nd = 0;
      i1.output8 = (k == 0) ? 32'h0 : 32'h5;
      i1.start = 1'b1;
      @(posedge clk); #1 i1.start = 1'b0;
      for (int t = 0; t < 10; t++) begin
        n9 += int'(i1.Enable9);
        nd += int'(i1.done);
        @(posedge clk); #1;
      end
      chk("iter1_e9", n9, 1);
      chk("iter1_done", nd, 1);
      chk("iter1_cnt", int'(i1.iter_cnt), 1);
    end

`ifdef CONTROL_UNIT_ABORT_EN
    // abort in the 2nd COMPUTE cycle: WRITE skipped, done still pulses
    sbq.push_back(mk(2, 0, 2, 4, -1, 1));
    pulse_run(0, 2);
    chk("aborted_sticky", int'(i8.aborted), 1);
    i8.abort = 1'b1;
    @(posedge clk); #1 i8.abort = 1'b0;
    chk("abort_idle_noeffect", int'(i8.busy), 0);
    chk("aborted_still", int'(i8.aborted), 1);
    sbq.push_back(mk(8, 1, 8, 11, -1, 0));
    pulse_run(0, 0);
`endif

    repeat (3) @(posedge clk); #1;
    chk("sb_drained_end", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
